alu_result_receiver: RTL and testbench
======================================

ALU_RESULT_RECEIVER -- requirements
Module: alu_result_receiver

Interface
REQ-001 Parameter: DEPTH, default 4, result buffer entries (power of two, min 2).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: pushout  input  1  ALU result valid (from ALU output side).
REQ-005 Port: z  input  8  ALU result data, qualified by pushout.
REQ-006 Port: cout  input  1  ALU carry out, qualified by pushout.
REQ-007 Port: stopin  output  1  backpressure to ALU; high = do not push.
REQ-008 Port: rd_en  input  1  consumer pop request.
REQ-009 Port: rd_valid  output  1  buffer head holds a valid result.
REQ-010 Port: rd_data  output  9  head entry {cout, z}.
REQ-011 Port: clr  input  1  synchronous clear of statistics only.
REQ-012 Port: acc_count  output  16  number of accepted results, saturating.
REQ-013 Port: checksum  output  8  modulo-256 sum of accepted z values.
REQ-014 Port: level  output  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-015 Transfer in SHALL occur on a rising edge where pushout=1 and stopin=0; {cout,z} written at tail.
REQ-016 pushout=1 with stopin=1 SHALL be ignored (no write, no stat update); sender holds data.
REQ-017 stopin SHALL be driven directly from registered state: 1 iff level==DEPTH.
REQ-018 Buffer SHALL be show-ahead: rd_valid=1 iff level>0; rd_data = head entry, combinational from storage.
REQ-019 Pop SHALL occur on a rising edge where rd_en=1 and rd_valid=1; rd_en with rd_valid=0 ignored.
REQ-020 Simultaneous push and pop with 0<level<DEPTH: level unchanged, both performed.
REQ-021 Simultaneous push and pop at level==0: push accepted, pop ignored; level becomes 1.
REQ-022 Pop at level==DEPTH: stopin=1 that cycle, so no push; level becomes DEPTH-1, stopin drops next cycle.
REQ-023 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 FSM states EMPTY, PARTIAL, FULL: EMPTY->PARTIAL on push; PARTIAL->FULL when push without pop brings level to DEPTH; PARTIAL->EMPTY when pop without push brings level to 0; FULL->PARTIAL on pop; all other cases hold.
REQ-025 acc_count SHALL increment by 1 per accepted transfer and saturate at 16'hFFFF.
REQ-026 checksum SHALL add z of each accepted transfer, wrapping modulo 256; cout not included.
REQ-027 clr=1 SHALL set acc_count and checksum to 0 next edge, taking priority over a same-cycle accept; the accepted result still enters the buffer.
REQ-028 Latency: result accepted on edge N SHALL be visible on rd_data with rd_valid=1 after edge N if buffer was empty.

Reset
REQ-029 rst low SHALL immediately force: state EMPTY, pointers 0, level 0, rd_valid 0, stopin 0, acc_count 0, checksum 0.
REQ-030 rst asserted mid-transfer or mid-pop SHALL discard all buffered results; storage contents need not be cleared.
REQ-031 First transfer after rst release SHALL be accepted on the first rising edge with pushout=1.

Structure
REQ-032 Shared package alu_pkg SHALL hold: result typedef struct {cout, z[7:0]}, receiver state enum, default DEPTH constant.
REQ-033 Storage and pointers SHALL be a sub-module alu_res_fifo; top holds FSM, handshake and statistics.
REQ-034 Top SHALL connect to the ALU via the alu_interface output-side signals (clk, rst, z, cout, pushout, stopin).

Verification
REQ-035 Reset then push z=8'h12,cout=1 -> rd_valid=1, rd_data=9'h112, acc_count=1, checksum=8'h12.
REQ-036 Push 4 results (DEPTH=4), rd_en=0 -> stopin=1, level=4; 5th push held ignored, acc_count=4.
REQ-037 Full, pop with pushout=1 -> no push that cycle, level=3; next cycle push accepted, level=4.
REQ-038 Push z=8'hF0 then 8'h20 -> checksum=8'h10 (wrap); clr with same-cycle push -> acc_count=0, checksum=0, level incremented.
REQ-039 Preload acc_count to 16'hFFFF via pushes (or force), push again -> acc_count stays 16'hFFFF.
REQ-040 Two entries buffered, assert rst low mid-cycle -> rd_valid, level, stopin 0 immediately; subsequent pop yields nothing.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result receiver.
//   alu_result_t : one buffered ALU result, packed as {cout, z}
//   rx_state_t   : occupancy state of the receiver buffer
//   ALU_RX_DEPTH : default number of buffer entries
package alu_pkg;

    typedef struct packed {
        logic       cout;
        logic [7:0] z;
    } alu_result_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } rx_state_t;

    localparam int unsigned ALU_RX_DEPTH = 4;

endpackage

// File: rtl/alu_res_fifo.sv
// Result storage and read/write pointers for the receiver.
// Full/empty gating is done by the caller; this block writes when wr_en is
// high and advances the read pointer when rd_en is high.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset (pointers only)
//   wr_en   : write wr_data at the tail
//   wr_data : result to store
//   rd_en   : discard the head entry
//   rd_data : head entry, combinational from storage
module alu_res_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = ALU_RX_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  alu_result_t wr_data,
    input  logic        rd_en,
    output alu_result_t rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    alu_result_t   mem_q [DEPTH];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable
    // once the pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_result_receiver.sv
// Receives results from the ALU output side, buffers them in a show-ahead
// FIFO and keeps running statistics over accepted results.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   pushout   : ALU result valid
//   z, cout   : ALU result data / carry, qualified by pushout
//   stopin    : backpressure to the ALU, high while the buffer is full
//   rd_en     : consumer pop request
//   rd_valid  : head entry is valid
//   rd_data   : head entry {cout, z}
//   clr       : synchronous clear of acc_count and checksum
//   acc_count : saturating count of accepted results
//   checksum  : modulo-256 sum of accepted z values
//   level     : current buffer occupancy
module alu_result_receiver
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = ALU_RX_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pushout,
    input  logic [7:0]               z,
    input  logic                     cout,
    output logic                     stopin,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [8:0]               rd_data,
    input  logic                     clr,
    output logic [15:0]              acc_count,
    output logic [7:0]               checksum,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    rx_state_t   state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  sum_q, sum_d;
    logic        push, pop;
    alu_result_t head;

    // FULL tracks level==DEPTH and EMPTY tracks level==0, so both handshake
    // outputs come straight from the state register.
    assign stopin   = (state_q == ST_FULL);
    assign rd_valid = (state_q != ST_EMPTY);

    assign push = pushout && !stopin;
    assign pop  = rd_en && rd_valid;

    alu_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ('{cout: cout, z: z}),
        .rd_en   (pop),
        .rd_data (head)
    );

    assign rd_data   = head;
    assign level     = level_q;
    assign acc_count = acc_q;
    assign checksum  = sum_q;

    always_comb begin
        level_d = level_q;
        state_d = state_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);

        case (state_q)
            ST_EMPTY: begin
                if (push) state_d = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (push && !pop && level_q == LW'(DEPTH - 1))
                    state_d = ST_FULL;
                else if (pop && !push && level_q == LW'(1))
                    state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (pop) state_d = ST_PARTIAL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // clr wins over a same-cycle accept; the result itself is still buffered.
    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        if (clr) begin
            acc_d = '0;
            sum_d = '0;
        end else if (push) begin
            if (acc_q != '1) acc_d = acc_q + 16'd1;
            sum_d = sum_q + z;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            level_q <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end

endmodule

// File: tb/tb_alu_result_receiver.sv
module tb_alu_result_receiver;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pushout = 1'b0;
    logic [7:0]  z = '0;
    logic        cout = 1'b0;
    logic        stopin;
    logic        rd_en = 1'b0;
    logic        rd_valid;
    logic [8:0]  rd_data;
    logic        clr = 1'b0;
    logic [15:0] acc_count;
    logic [7:0]  checksum;
    logic [2:0]  level;

    int checks = 0;
    int failures = 0;

    alu_result_receiver #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .pushout   (pushout),
        .z         (z),
        .cout      (cout),
        .stopin    (stopin),
        .rd_en     (rd_en),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .clr       (clr),
        .acc_count (acc_count),
        .checksum  (checksum),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a queue of buffered results plus plain counters.
    logic [8:0] mq[$];
    int         mcnt = 0;
    logic [7:0] msum = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mcnt <= 0;
            msum <= '0;
        end else begin
            if (clr) begin
                mcnt <= 0;
                msum <= '0;
            end else if (pushout && mq.size() < DEPTH) begin
                if (mcnt < 65535) mcnt <= mcnt + 1;
                msum <= msum + z;
            end
            if (pushout && mq.size() < DEPTH) begin
                if (rd_en && mq.size() > 0) void'(mq.pop_front());
                mq.push_back({cout, z});
            end else if (rd_en && mq.size() > 0) begin
                void'(mq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("m_rd_valid", {31'd0, rd_valid}, {31'd0, mq.size() > 0});
            if (mq.size() > 0) chk("m_rd_data", {23'd0, rd_data}, {23'd0, mq[0]});
            chk("m_level", {29'd0, level}, mq.size());
            chk("m_stopin", {31'd0, stopin}, {31'd0, mq.size() == DEPTH});
            chk("m_acc_count", {16'd0, acc_count}, mcnt);
            chk("m_checksum", {24'd0, checksum}, {24'd0, msum});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_stopin", {31'd0, stopin}, 32'd0);
        chk("rst_acc", {16'd0, acc_count}, 32'd0);
        chk("rst_sum", {24'd0, checksum}, 32'd0);
        rst = 1'b1;
        tick();

        // single push, show-ahead head
        pushout = 1'b1; z = 8'h12; cout = 1'b1;
        tick();
        pushout = 1'b0;
        chk("p1_valid", {31'd0, rd_valid}, 32'd1);
        chk("p1_data", {23'd0, rd_data}, 32'h112);
        chk("p1_acc", {16'd0, acc_count}, 32'd1);
        chk("p1_sum", {24'd0, checksum}, 32'h12);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("p1_pop_level", {29'd0, level}, 32'd0);

        rst = 1'b0; #1; rst = 1'b1;

        // fill to DEPTH, then a held push
        for (int i = 0; i < 4; i++) begin
            pushout = 1'b1; z = 8'hA0 + 8'(i); cout = i[0];
            tick();
        end
        z = 8'h55; cout = 1'b0;
        chk("full_stopin", {31'd0, stopin}, 32'd1);
        chk("full_level", {29'd0, level}, 32'd4);
        chk("full_acc", {16'd0, acc_count}, 32'd4);
        tick(); tick();
        chk("held_level", {29'd0, level}, 32'd4);
        chk("held_acc", {16'd0, acc_count}, 32'd4);

        // pop while full and pushing: push is refused that edge
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fpop_level", {29'd0, level}, 32'd3);
        chk("fpop_stopin", {31'd0, stopin}, 32'd0);
        chk("fpop_acc", {16'd0, acc_count}, 32'd4);
        chk("fpop_head", {23'd0, rd_data}, 32'h1A1);
        tick();
        pushout = 1'b0;
        chk("refill_level", {29'd0, level}, 32'd4);
        chk("refill_acc", {16'd0, acc_count}, 32'd5);
        rd_en = 1'b1;
        repeat (4) tick();
        rd_en = 1'b0;
        chk("drain_level", {29'd0, level}, 32'd0);

        // checksum wrap and clr priority
        clr = 1'b1; tick(); clr = 1'b0;
        pushout = 1'b1; z = 8'hF0; cout = 1'b0; tick();
        z = 8'h20; tick();
        pushout = 1'b0;
        chk("wrap_sum", {24'd0, checksum}, 32'h10);
        chk("wrap_acc", {16'd0, acc_count}, 32'd2);
        clr = 1'b1; pushout = 1'b1; z = 8'h33;
        tick();
        clr = 1'b0; pushout = 1'b0;
        chk("clr_acc", {16'd0, acc_count}, 32'd0);
        chk("clr_sum", {24'd0, checksum}, 32'd0);
        chk("clr_level", {29'd0, level}, 32'd3);
        rd_en = 1'b1; repeat (3) tick(); rd_en = 1'b0;

        // push+pop at level 0, then at level 1
        pushout = 1'b1; rd_en = 1'b1; z = 8'h44;
        tick();
        chk("pp0_level", {29'd0, level}, 32'd1);
        chk("pp0_data", {23'd0, rd_data}, 32'h044);
        z = 8'h45;
        tick();
        chk("pp1_level", {29'd0, level}, 32'd1);
        chk("pp1_data", {23'd0, rd_data}, 32'h045);
        pushout = 1'b0;
        tick();
        rd_en = 1'b0;

        // reset with two entries buffered
        pushout = 1'b1; z = 8'h61; tick();
        z = 8'h62; tick();
        pushout = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, rd_valid}, 32'd0);
        chk("mrst_level", {29'd0, level}, 32'd0);
        chk("mrst_stopin", {31'd0, stopin}, 32'd0);
        rst = 1'b1;
        pushout = 1'b1;
        repeat (4) tick();
        pushout = 1'b0;
        rst = 1'b0;
        #1;
        chk("frst_stopin", {31'd0, stopin}, 32'd0);
        chk("frst_level", {29'd0, level}, 32'd0);
        rst = 1'b1;
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("rpop_valid", {31'd0, rd_valid}, 32'd0);
        chk("rpop_level", {29'd0, level}, 32'd0);

        // first push after reset release
        pushout = 1'b1; z = 8'h7E; cout = 1'b0;
        tick();
        pushout = 1'b0;
        chk("first_level", {29'd0, level}, 32'd1);
        chk("first_acc", {16'd0, acc_count}, 32'd1);
        chk("first_data", {23'd0, rd_data}, 32'h07E);
        rd_en = 1'b1; tick(); rd_en = 1'b0;

        // saturation of acc_count
        clr = 1'b1; tick(); clr = 1'b0;
        pushout = 1'b1; rd_en = 1'b1; z = 8'h01;
        repeat (65535) tick();
        chk("sat_acc", {16'd0, acc_count}, 32'hFFFF);
        chk("sat_sum", {24'd0, checksum}, 32'hFF);
        tick();
        chk("sat_hold_acc", {16'd0, acc_count}, 32'hFFFF);
        chk("sat_hold_sum", {24'd0, checksum}, 32'h00);
        pushout = 1'b0;
        tick();
        rd_en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
